// File: rtl/branch_predict_resolve_if.sv
// ============================================================================
// branch_predict_resolve_if : predict/resolve bus for branch_predict_resolve
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface branch_predict_resolve_if #(
    parameter int XLEN = 32
);
    logic            pred_valid_in;
    logic [XLEN-1:0] pred_pc_in;
    logic            pred_valid_out;
    logic            pred_taken_out;

    logic            res_valid_in;
    logic            res_ready_out;
    logic [4:0]      opcode_6_to_2_in;
    logic [2:0]      funct3_in;
    logic [XLEN-1:0] rs1_in;
    logic [XLEN-1:0] rs2_in;
    logic [XLEN-1:0] res_pc_in;
    logic            res_pred_taken_in;
    logic            flush_in;
    logic            res_valid_out;
    logic            branch_taken_out;
    logic            mispredict_out;
    logic [15:0]     mispredict_count_out;

    modport slave (
        input  pred_valid_in, pred_pc_in,
        output pred_valid_out, pred_taken_out,
        input  res_valid_in, opcode_6_to_2_in, funct3_in, rs1_in, rs2_in,
        input  res_pc_in, res_pred_taken_in, flush_in,
        output res_ready_out, res_valid_out, branch_taken_out, mispredict_out,
        output mispredict_count_out
    );

    modport master (
        output pred_valid_in, pred_pc_in,
        input  pred_valid_out, pred_taken_out,
        output res_valid_in, opcode_6_to_2_in, funct3_in, rs1_in, rs2_in,
        output res_pc_in, res_pred_taken_in, flush_in,
        input  res_ready_out, res_valid_out, branch_taken_out, mispredict_out,
        input  mispredict_count_out
    );
endinterface

`default_nettype wire

// File: rtl/branch_predict_resolve.sv
// ============================================================================
// branch_predict_resolve : 2-bit BHT predictor with branch compare/resolve unit
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module branch_predict_resolve #(
    parameter int         XLEN       = 32,
    parameter int         BHT_DEPTH  = 64,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  wire logic                clk_in,
    input  wire logic                rst_n_in,
    branch_predict_resolve_if.slave  bus
);
    localparam int         IDX_W        = $clog2(BHT_DEPTH);
    localparam logic [4:0] C_OPC_BRANCH = 5'b11000;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_sweep;
    logic [IDX_W-1:0] w_sweep_nxt;
    logic             w_ready;

    logic [1:0]       r_bht [BHT_DEPTH];

    logic             r_pred_valid;
    logic             r_pred_taken;
    logic             r_res_valid;
    logic             r_branch_taken;
    logic             r_mispredict;
    logic [15:0]      r_mis_count;

    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_cur_ctr;
    logic [1:0]       w_new_ctr;
    logic             w_is_branch;
    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic             w_cond;
    logic             w_taken;
    logic             w_mispredict;
    logic             w_fire;
    logic             w_unused_pc;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        w_ready     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_sweep_nxt = r_sweep + 1'b1;
                if (r_sweep == IDX_W'(BHT_DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ready = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign w_pred_idx  = bus.pred_pc_in[IDX_W+1:2];
    assign w_upd_idx   = bus.res_pc_in[IDX_W+1:2];
    assign w_unused_pc = ^{bus.pred_pc_in[XLEN-1:IDX_W+2], bus.pred_pc_in[1:0],
                           bus.res_pc_in[XLEN-1:IDX_W+2], bus.res_pc_in[1:0]};

    assign w_is_branch = (bus.opcode_6_to_2_in == C_OPC_BRANCH) &&
                         (bus.funct3_in != 3'b010) && (bus.funct3_in != 3'b011);
    assign w_eq  = (bus.rs1_in == bus.rs2_in);
    assign w_lt  = ($signed(bus.rs1_in) < $signed(bus.rs2_in));
    assign w_ltu = (bus.rs1_in < bus.rs2_in);

    always_comb begin
        w_cond = 1'b0;
        case (bus.funct3_in)
            3'b000:  w_cond = w_eq;
            3'b001:  w_cond = !w_eq;
            3'b100:  w_cond = w_lt;
            3'b101:  w_cond = !w_lt;
            3'b110:  w_cond = w_ltu;
            3'b111:  w_cond = !w_ltu;
            default: w_cond = 1'b0;
        endcase
    end

    // Non-branches resolve as not-taken, so a taken prediction on them is a mispredict.
    assign w_taken      = w_is_branch & w_cond;
    assign w_mispredict = w_taken ^ bus.res_pred_taken_in;
    assign w_fire       = bus.res_valid_in & w_ready & ~bus.flush_in;

    assign w_cur_ctr = r_bht[w_upd_idx];
    always_comb begin
        w_new_ctr = w_cur_ctr;
        if (w_taken) begin
            if (w_cur_ctr != 2'b11) w_new_ctr = w_cur_ctr + 2'b01;
        end else begin
            if (w_cur_ctr != 2'b00) w_new_ctr = w_cur_ctr - 2'b01;
        end
    end

    // Table has no reset; the INIT sweep is its only initialisation.
    always_ff @(posedge clk_in) begin
        if (r_state == ST_INIT) begin
            r_bht[r_sweep] <= INIT_STATE;
        end else if (w_fire && w_is_branch) begin
            r_bht[w_upd_idx] <= w_new_ctr;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pred_valid   <= 1'b0;
            r_pred_taken   <= 1'b0;
            r_res_valid    <= 1'b0;
            r_branch_taken <= 1'b0;
            r_mispredict   <= 1'b0;
            r_mis_count    <= 16'h0000;
        end else begin
            r_pred_valid <= bus.pred_valid_in & ~bus.flush_in;
            r_pred_taken <= (r_state == ST_RUN) ? r_bht[w_pred_idx][1] : 1'b0;
            r_res_valid  <= w_fire;
            if (w_fire) begin
                r_branch_taken <= w_taken;
                r_mispredict   <= w_mispredict;
                if (w_mispredict && (r_mis_count != 16'hFFFF)) begin
                    r_mis_count <= r_mis_count + 16'h0001;
                end
            end
        end
    end

    assign bus.res_ready_out        = w_ready;
    assign bus.pred_valid_out       = r_pred_valid;
    assign bus.pred_taken_out       = r_pred_taken;
    assign bus.res_valid_out        = r_res_valid;
    assign bus.branch_taken_out     = r_branch_taken;
    assign bus.mispredict_out       = r_mispredict;
    assign bus.mispredict_count_out = r_mis_count;

endmodule

`default_nettype wire
